// File: rtl/sqrt_operand_issuer_pkg.sv
// Shared types and constants for the asynchronous CORDIC square-root path:
// issuer states, the dual-rail operand codeword and binary32 special results.
package pa_AsyncCordic;

  localparam int EXP_W = 8;
  localparam int RAD_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RTZ  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [RAD_W-1:0] rad;
  } payload_t;

  // Each payload bit travels as a (data_1, data_0) rail pair; 76 bits in total.
  typedef struct packed {
    payload_t data_1;
    payload_t data_0;
  } operand_t;

  localparam logic [31:0] QNAN32    = 32'h7FC0_0000;
  localparam logic [31:0] INF32     = 32'h7F80_0000;
  localparam operand_t    DR_SPACER = '0;

  function automatic operand_t dr_encode(input payload_t p);
    operand_t o;
    o.data_1 = p;
    o.data_0 = payload_t'(~p);
    return o;
  endfunction

endpackage

// File: rtl/sqrt_operand_issuer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sqrt_operand_issuer.sv
// Accepts binary32 operands, diverts special values to a bypass port and issues
// normal ones to the asynchronous CORDIC core as four-phase dual-rail codewords.
//
// state | meaning
// IDLE  | op at spacer; may accept an operand when no bypass result is pending
// DATA  | codeword held on op, waiting for the core to acknowledge
// RTZ   | op back at spacer, waiting for the acknowledge to return to zero
module sqrt_operand_issuer
  import pa_AsyncCordic::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output operand_t    op,
  input  logic        op_ack,
  output logic        byp_valid,
  input  logic        byp_ready,
  output logic [31:0] byp_data
);

  issue_state_e state_q;
  logic         ack_s;
  logic [1:0]   arm_cnt_q;
  logic         arm_done;
  logic         accept;

  logic         sgn;
  logic [7:0]   bexp;
  logic [22:0]  frac;
  logic         e_odd;
  logic [7:0]   root_exp;
  logic [29:0]  radicand;
  payload_t     payload;

  logic         is_zero;
  logic         is_nan;
  logic         is_special;
  logic [31:0]  special_data;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (op_ack),
    .q     (ack_s)
  );

  assign sgn  = in_data[31];
  assign bexp = in_data[30:23];
  assign frac = in_data[22:0];

  // E = e - 127 is odd exactly when e is even, so the halved exponent
  // ((E - odd) >>> 1) + 127 reduces to e[7:1] + 63 + e[0].
  assign e_odd    = ~bexp[0];
  assign root_exp = {1'b0, bexp[7:1]} + 8'd63 + {7'd0, bexp[0]};
  assign radicand = e_odd ? {1'b1, frac, 6'b0} : {1'b0, 1'b1, frac, 5'b0};

  always_comb begin
    payload     = '0;
    payload.exp = root_exp;
    payload.rad = radicand;
  end

  assign is_zero    = (bexp == 8'd0);
  assign is_nan     = (sgn && !is_zero) || ((bexp == 8'hFF) && (frac != 23'd0));
  assign is_special = is_zero || sgn || (bexp == 8'hFF);

  always_comb begin
    special_data = INF32;
    if (is_zero) begin
      special_data = {sgn, 31'b0};
    end else if (is_nan) begin
      special_data = QNAN32;
    end
  end

  // The synchronizer clears on reset even if the core is still acknowledging;
  // hold off acceptance until a live op_ack level has had time to reach ack_s.
  assign arm_done = (arm_cnt_q == 2'd0);
  assign in_ready = (state_q == ST_IDLE) && !byp_valid && !ack_s && arm_done;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= 2'd2;
    end else if (!arm_done) begin
      arm_cnt_q <= arm_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op        <= DR_SPACER;
      byp_valid <= 1'b0;
      byp_data  <= 32'd0;
    end else begin
      if (byp_valid && byp_ready) begin
        byp_valid <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_special) begin
              byp_valid <= 1'b1;
              byp_data  <= special_data;
            end else begin
              op      <= dr_encode(payload);
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (ack_s) begin
            op      <= DR_SPACER;
            state_q <= ST_RTZ;
          end
        end
        ST_RTZ: begin
          if (!ack_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          op      <= DR_SPACER;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_operand_issuer.sv
// Randomized bench for sqrt_operand_issuer against an arithmetic reference model
// of operand classification, exponent halving and dual-rail encoding.
module tb_sqrt_operand_issuer;
  import pa_AsyncCordic::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  operand_t    op;
  logic        op_ack = 1'b0;
  logic        byp_valid;
  logic        byp_ready = 1'b0;
  logic [31:0] byp_data;

  int total = 0;
  int bad = 0;

  sqrt_operand_issuer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .op_ack    (op_ack),
    .byp_valid (byp_valid),
    .byp_ready (byp_ready),
    .byp_data  (byp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: classify, then E = e-127, exp = (E-odd)/2 + 127, mantissa at bit 28 (29 if odd).
  function automatic void ref_model(input logic [31:0] x, output bit special,
                                    output logic [31:0] byp, output logic [75:0] code);
    int          e;
    int          ue;
    int          odd;
    int          rexp;
    longint      rad;
    logic [37:0] p;
    e = int'(x[30:23]);
    special = 1'b1;
    byp = 32'd0;
    code = '0;
    if (e == 0) begin
      byp = x[31] ? 32'h8000_0000 : 32'h0000_0000;
    end else if (x[31] || (e == 255 && x[22:0] != 23'd0)) begin
      byp = 32'h7FC0_0000;
    end else if (e == 255) begin
      byp = 32'h7F80_0000;
    end else begin
      special = 1'b0;
      ue = e - 127;
      odd = (ue % 2 != 0) ? 1 : 0;
      rexp = (ue - odd) / 2 + 127;
      rad = (longint'(x[22:0]) + longint'(8388608)) * ((odd != 0) ? 64 : 32);
      p = {rexp[7:0], rad[29:0]};
      code = {p, ~p};
    end
  endfunction

  task automatic offer(input logic [31:0] x, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = x;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("accept_timeout", {75'd0, in_ready}, 76'd1);
  endtask

  task automatic finish_handshake(input logic [75:0] ec, input int ack_delay, input int ack_hold);
    int n;
    for (int i = 0; i <= ack_delay; i++) begin
      check("op_code", op, ec);
      check("data_in_ready", {75'd0, in_ready}, 76'd0);
      if (i < ack_delay) tick();
    end
    op_ack = 1'b1;
    n = 0;
    while (op !== DR_SPACER && n < 4) begin
      tick();
      n++;
    end
    check("rtz_spacer", op, 76'd0);
    check("spacer_latency", 76'(n), 76'd3);
    for (int i = 0; i < ack_hold; i++) begin
      tick();
      check("rtz_op", op, 76'd0);
      check("rtz_in_ready", {75'd0, in_ready}, 76'd0);
    end
    op_ack = 1'b0;
    n = 0;
    while (!in_ready && n < 6) begin
      tick();
      n++;
    end
    check("ready_return", {75'd0, in_ready}, 76'd1);
    check("ready_latency", 76'(n), 76'd3);
  endtask

  task automatic run_one(input logic [31:0] x, input int byp_hold, input int ack_delay,
                         input int ack_hold);
    bit          sp;
    bit          ok;
    logic [31:0] eb;
    logic [75:0] ec;
    ref_model(x, sp, eb, ec);
    offer(x, ok);
    if (!ok) return;
    if (sp) begin
      for (int i = 0; i <= byp_hold; i++) begin
        check("byp_valid", {75'd0, byp_valid}, 76'd1);
        check("byp_data", {44'd0, byp_data}, {44'd0, eb});
        check("byp_op_spacer", op, 76'd0);
        check("byp_in_ready", {75'd0, in_ready}, 76'd0);
        if (i < byp_hold) tick();
      end
      byp_ready = 1'b1;
      tick();
      byp_ready = 1'b0;
      check("byp_clear", {75'd0, byp_valid}, 76'd0);
    end else begin
      finish_handshake(ec, ack_delay, ack_hold);
    end
  endtask

  initial begin
    bit          ok;
    bit          sp;
    logic [31:0] eb;
    logic [75:0] ec;
    logic [37:0] want;
    logic [31:0] x;
    int          n;

    #1;
    check("rst_op", op, 76'd0);
    check("rst_byp_valid", {75'd0, byp_valid}, 76'd0);
    check("rst_byp_data", {44'd0, byp_data}, 76'd0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 5) begin
      tick();
      n++;
    end
    check("rst_ready", {75'd0, in_ready}, 76'd1);

    // 4.0: exponent 128, only radicand bit 28
    ref_model(32'h4080_0000, sp, eb, ec);
    offer(32'h4080_0000, ok);
    want = {8'd128, 30'h1000_0000};
    check("four_d1", {38'd0, op[75:38]}, {38'd0, want});
    check("four_d0", {38'd0, op[37:0]}, {38'd0, ~want});
    finish_handshake(ec, 1, 1);

    // 2.0: odd exponent, exponent 127, only radicand bit 29
    ref_model(32'h4000_0000, sp, eb, ec);
    offer(32'h4000_0000, ok);
    want = {8'd127, 30'h2000_0000};
    check("two_d1", {38'd0, op[75:38]}, {38'd0, want});
    check("two_d0", {38'd0, op[37:0]}, {38'd0, ~want});
    finish_handshake(ec, 0, 2);

    run_one(32'hBF80_0000, 1, 0, 0);
    run_one(32'h7FC0_0001, 0, 0, 0);
    run_one(32'h0000_0000, 2, 0, 0);
    run_one(32'h8000_0000, 0, 0, 0);
    run_one(32'h7F80_0000, 5, 0, 0);
    run_one(32'h0000_0001, 0, 0, 0);
    run_one(32'h0080_0000, 0, 1, 0);
    run_one(32'h7F7F_FFFF, 0, 0, 1);

    // reset pulse during DATA while the core is acknowledging
    ref_model(32'h4040_0000, sp, eb, ec);
    offer(32'h4040_0000, ok);
    op_ack = 1'b1;
    tick();
    check("pre_rst_code", op, ec);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_op", op, 76'd0);
    check("mid_rst_byp", {75'd0, byp_valid}, 76'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ready", {75'd0, in_ready}, 76'd0);
      check("post_rst_op", op, 76'd0);
    end
    op_ack = 1'b0;
    tick();
    check("ack_drop_ready1", {75'd0, in_ready}, 76'd0);
    tick();
    check("ack_drop_ready2", {75'd0, in_ready}, 76'd1);

    // back-to-back: -1.0 must wait for the 1.0 handshake to complete
    ref_model(32'h3F80_0000, sp, eb, ec);
    offer(32'h3F80_0000, ok);
    in_valid = 1'b1;
    in_data = 32'hBF80_0000;
    check("b2b_code", op, ec);
    op_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b2b_hold_ready", {75'd0, in_ready}, 76'd0);
      tick();
    end
    check("b2b_spacer", op, 76'd0);
    op_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b2b_rtz_ready", {75'd0, in_ready}, 76'd0);
      check("b2b_no_byp", {75'd0, byp_valid}, 76'd0);
      tick();
    end
    check("b2b_ready", {75'd0, in_ready}, 76'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_byp_valid", {75'd0, byp_valid}, 76'd1);
    check("b2b_byp_data", {44'd0, byp_data}, {44'd0, 32'h7FC0_0000});
    check("b2b_op", op, 76'd0);
    byp_ready = 1'b1;
    tick();
    byp_ready = 1'b0;
    check("b2b_byp_clear", {75'd0, byp_valid}, 76'd0);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: x = $urandom;
        1: x = {1'($urandom), 8'd0, 23'($urandom)};
        2: x = {1'($urandom), 8'hFF, (($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom))};
        3: x = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
        default: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      run_one(x, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
